// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and config register map.
package irq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE    = 2'd0;
  localparam logic [1:0] ADDR_MODE      = 2'd1;
  localparam logic [1:0] ADDR_PENDING   = 2'd2;
  localparam logic [1:0] ADDR_INSERVICE = 2'd3;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest set bit of req_i wins.
module irq_priority_encoder #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned VEC_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic             valid_o,
  output logic [VEC_W-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Walk from the top down so the lowest set index is the last assignment.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = VEC_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with req/ack/eoi CPU handshake.
// Define IRQ_SYNC_EN to pass every irq_in bit through a 2-flop synchronizer.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned VEC_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_rdata,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             irq_eoi
);

  localparam logic [N_IRQ-1:0] One = N_IRQ'(1);

  logic [N_IRQ-1:0] irq_s;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] insvc_q, insvc_d;
  logic [N_IRQ-1:0] prev_q;
  logic             req_q, req_d;
  logic [VEC_W-1:0] vec_q, vec_d;

  logic [N_IRQ-1:0] candidates, w1c, ack_clr, vec_onehot;
  logic             win_valid, ack_fire, eoi_fire;
  logic [VEC_W-1:0] win_idx;

  assign candidates = pending_q & enable_q & ~insvc_q;

  irq_priority_encoder #(
    .N_IRQ(N_IRQ),
    .VEC_W(VEC_W)
  ) u_prio (
    .req_i  (candidates),
    .valid_o(win_valid),
    .idx_o  (win_idx)
  );

  always_comb begin
    vec_onehot = One << vec_q;
    ack_fire   = (state_q == StReq) && irq_ack;
    eoi_fire   = (state_q == StService) && irq_eoi;
    ack_clr    = ack_fire ? vec_onehot : '0;
    w1c        = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : '0;
    enable_d   = (cfg_we && cfg_addr == ADDR_ENABLE) ? cfg_wdata : enable_q;
    mode_d     = (cfg_we && cfg_addr == ADDR_MODE) ? cfg_wdata : mode_q;
    // Edge channels: a new rising edge beats any clear in the same cycle.
    pending_d  = (mode_q & ((pending_q & ~w1c & ~ack_clr) | (irq_s & ~prev_q)))
               | (~mode_q & irq_s);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    insvc_d = insvc_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          vec_d   = win_idx;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack_fire) begin
          insvc_d = insvc_q | vec_onehot;
          req_d   = 1'b0;
          state_d = StService;
        end
      end
      StService: begin
        if (eoi_fire) begin
          insvc_d = insvc_q & ~vec_onehot;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      insvc_q   <= '0;
      prev_q    <= '0;
      req_q     <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      insvc_q   <= insvc_d;
      prev_q    <= irq_s;
      req_q     <= req_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    unique case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata = enable_q;
      ADDR_MODE:    cfg_rdata = mode_q;
      ADDR_PENDING: cfg_rdata = pending_q;
      default:      cfg_rdata = insvc_q;
    endcase
  end

  assign irq_req = req_q;
  assign irq_vec = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (N_IRQ = 8).
module tb_irq_controller;
  import irq_pkg::*;

`ifdef IRQ_SYNC_EN
  localparam int SyncDly = 2;
`else
  localparam int SyncDly = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       irq_req;
  logic [2:0] irq_vec;
  logic       irq_ack;
  logic       irq_eoi;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_controller #(
    .N_IRQ(8),
    .VEC_W(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .irq_req  (irq_req),
    .irq_vec  (irq_vec),
    .irq_ack  (irq_ack),
    .irq_eoi  (irq_eoi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", irq_req); end
    n_cmp++;
    if (irq_vec !== 3'd0) begin n_fail++; $display("FAIL reset_vec got %0d want 0", irq_vec); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      n_cmp++;
      if (cfg_rdata !== 8'h00) begin
        n_fail++; $display("FAIL reset_reg%0d got %h want 00", a, cfg_rdata);
      end
    end
  endtask

  task automatic test_level();
    cfg_write(ADDR_ENABLE, 8'h01);
    irq_in = 8'h01;
    repeat (SyncDly + 1) tick();
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h01) begin n_fail++; $display("FAIL lvl_pending got %h want 01", cfg_rdata); end
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL lvl_req_early got %b want 0", irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_vec !== 3'd0) begin
      n_fail++; $display("FAIL lvl_req got req=%b vec=%0d want req=1 vec=0", irq_req, irq_vec);
    end
    pulse_ack();
    cfg_addr = ADDR_INSERVICE; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h01 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL lvl_ack got insvc=%h req=%b want 01/0", cfg_rdata, irq_req);
    end
    irq_in = 8'h00;
    repeat (SyncDly + 2) tick();
    pulse_eoi();
    cfg_addr = ADDR_INSERVICE; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h00 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL lvl_eoi got insvc=%h req=%b want 00/0", cfg_rdata, irq_req);
    end
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL lvl_idle got %b want 0", irq_req); end
  endtask

  task automatic test_priority();
    cfg_write(ADDR_ENABLE, 8'hFF);
    irq_in = 8'h24;
    repeat (SyncDly + 2) tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_vec !== 3'd2) begin
      n_fail++; $display("FAIL prio_first got req=%b vec=%0d want 1/2", irq_req, irq_vec);
    end
    pulse_ack();
    n_cmp++;
    if (irq_req !== 1'b0 || irq_vec !== 3'd2) begin
      n_fail++; $display("FAIL prio_svc got req=%b vec=%0d want 0/2", irq_req, irq_vec);
    end
    irq_in = 8'h20;
    repeat (SyncDly + 2) tick();
    pulse_eoi();
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_vec !== 3'd5) begin
      n_fail++; $display("FAIL prio_second got req=%b vec=%0d want 1/5", irq_req, irq_vec);
    end
    pulse_ack();
    irq_in = 8'h00;
    repeat (SyncDly + 2) tick();
    pulse_eoi();
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_drain got %b want 0", irq_req); end
  endtask

  task automatic test_edge();
    cfg_write(ADDR_ENABLE, 8'h00);
    cfg_write(ADDR_MODE, 8'h08);
    irq_in = 8'h08; tick(); irq_in = 8'h00;
    repeat (SyncDly + 1) tick();
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h08 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL edge_latch got pend=%h req=%b want 08/0", cfg_rdata, irq_req);
    end
    cfg_write(ADDR_ENABLE, 8'h08);
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL edge_en_early got %b want 0", irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_vec !== 3'd3) begin
      n_fail++; $display("FAIL edge_req got req=%b vec=%0d want 1/3", irq_req, irq_vec);
    end
    pulse_ack();
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL edge_ack_clr got %h want 00", cfg_rdata); end
    // Rising edge lands in the same cycle as the W1C.
    irq_in = 8'h08;
    repeat (SyncDly) tick();
    cfg_write(ADDR_PENDING, 8'h08);
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h08) begin n_fail++; $display("FAIL edge_set_wins got %h want 08", cfg_rdata); end
    irq_in = 8'h00;
    repeat (SyncDly + 1) tick();
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h08) begin n_fail++; $display("FAIL edge_sticky got %h want 08", cfg_rdata); end
    cfg_write(ADDR_PENDING, 8'h08);
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL edge_w1c got %h want 00", cfg_rdata); end
    pulse_eoi();
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL edge_drain got %b want 0", irq_req); end
  endtask

  task automatic test_freeze();
    cfg_write(ADDR_MODE, 8'h00);
    cfg_write(ADDR_ENABLE, 8'hFF);
    irq_in = 8'h10;
    repeat (SyncDly + 2) tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_vec !== 3'd4) begin
      n_fail++; $display("FAIL frz_req got req=%b vec=%0d want 1/4", irq_req, irq_vec);
    end
    irq_in = 8'h12;
    repeat (SyncDly + 2) tick();
    cfg_addr = ADDR_PENDING; #1;
    n_cmp++;
    if (irq_vec !== 3'd4 || irq_req !== 1'b1 || cfg_rdata !== 8'h12) begin
      n_fail++; $display("FAIL frz_hiprio got vec=%0d req=%b pend=%h want 4/1/12",
                         irq_vec, irq_req, cfg_rdata);
    end
    cfg_write(ADDR_ENABLE, 8'hEF);
    irq_in = 8'h02;
    repeat (SyncDly + 2) tick();
    n_cmp++;
    if (irq_vec !== 3'd4 || irq_req !== 1'b1) begin
      n_fail++; $display("FAIL frz_dis_drop got vec=%0d req=%b want 4/1", irq_vec, irq_req);
    end
    pulse_ack();
    cfg_addr = ADDR_INSERVICE; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h10 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL frz_ack got insvc=%h req=%b want 10/0", cfg_rdata, irq_req);
    end
    pulse_eoi();
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_vec !== 3'd1) begin
      n_fail++; $display("FAIL frz_next got req=%b vec=%0d want 1/1", irq_req, irq_vec);
    end
    pulse_ack();
    cfg_addr = ADDR_INSERVICE; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h02) begin n_fail++; $display("FAIL frz_svc1 got %h want 02", cfg_rdata); end
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h00;
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++;
    if (irq_req !== 1'b0 || irq_vec !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid got req=%b vec=%0d want 0/0", irq_req, irq_vec);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      n_cmp++;
      if (cfg_rdata !== 8'h00) begin
        n_fail++; $display("FAIL rst_mid_reg%0d got %h want 00", a, cfg_rdata);
      end
    end
    pulse_eoi();
    pulse_ack();
    cfg_write(ADDR_INSERVICE, 8'hFF);
    cfg_addr = ADDR_INSERVICE; #1;
    n_cmp++;
    if (cfg_rdata !== 8'h00 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_stray got insvc=%h req=%b want 00/0", cfg_rdata, irq_req);
    end
    irq_in = 8'h01;
    repeat (SyncDly + 3) tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL rst_need_enable got %b want 0", irq_req); end
    irq_in = 8'h00;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    test_reset();
    test_level();
    test_priority();
    test_edge();
    test_freeze();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Parametrised interrupt controller. It replaces the flat OR-and-register aggregation of timer and I/O interrupt lines feeding the CPU. It latches N sources into per-channel pending bits, with per-channel enable and edge/level mode. It runs a fixed-priority request/acknowledge/end-of-interrupt handshake with the CPU and presents a stable vector number.

Parameters:
N_IRQ, 8, number of interrupt source channels (2..32)
VEC_W, $clog2(N_IRQ), width of vector number output

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high; clock clk
irq_in  input  N_IRQ  raw interrupt sources (timer, i/o, ...), bit 0 highest priority
cfg_we  input  1  config register write strobe
cfg_addr  input  2  register select: 0 ENABLE, 1 MODE, 2 PENDING, 3 INSERVICE
cfg_wdata  input  N_IRQ  config write data
cfg_rdata  output  N_IRQ  combinational read of register at cfg_addr
irq_req  output  1  interrupt request to CPU
irq_vec  output  VEC_W  channel number of request/current service
irq_ack  input  1  CPU accepts request (1-cycle pulse)
irq_eoi  input  1  CPU end-of-interrupt (1-cycle pulse)

Behaviour:
- Reset values: enable=0, mode=0 (all level), pending=0, in_service=0, prev_in=0, state=IDLE, irq_req=0, irq_vec=0.
- MODE bit=1 selects edge; 0 selects level.
  - Edge channel: rising edge (irq_in & ~prev_in) sets pending. Stays set until acked or W1C.
  - Level channel: pending mirrors irq_in each cycle. Ack and W1C have no lasting effect.
- Pending is captured regardless of enable. The request candidate set is pending & enable & ~in_service.
- Write ENABLE/MODE: value takes effect the next cycle. Write PENDING: write-1-to-clear on edge channels. If a clear and a new edge hit the same bit in the same cycle, set wins. Write INSERVICE: ignored.
- Priority: lowest index among candidates, via combinational encoder.
- FSM states:
  - IDLE: if any candidate, latch irq_vec=winner, irq_req<=1, go REQ.
  - REQ: irq_vec frozen. A higher-priority arrival does not change it, and neither does disabling the channel or a level drop. On irq_ack: in_service[irq_vec]<=1, clear pending[irq_vec] if edge, irq_req<=0, go SERVICE.
  - SERVICE: irq_vec held. On irq_eoi: in_service[irq_vec]<=0, go IDLE. The next request can issue on the following cycle.
  - irq_ack outside REQ is ignored. irq_eoi outside SERVICE is ignored.
- Latency: irq_in high at edge k gives pending=1 after k and irq_req=1 after k+1, i.e. 2 cycles from source to request.
- No nesting: one interrupt in service at a time.
- Reset mid-handshake returns to IDLE with all state cleared; the CPU must re-enable.

Optional Feature:
IRQ_SYNC_EN defined: each irq_in bit passes through a 2-flop synchronizer (reset 0) before edge detection and pending logic. Source-to-request latency becomes 4 cycles; use for asynchronous sources such as buttons and switches.
Undefined: irq_in is used directly; latency is 2 cycles.

Decomposition:
- Package irq_pkg: FSM state encoding (IDLE, REQ, SERVICE) and register address constants (ADDR_ENABLE=0, ADDR_MODE=1, ADDR_PENDING=2, ADDR_INSERVICE=3).
- Sub-module irq_priority_encoder: combinational, N_IRQ-bit request vector in, valid + VEC_W index out. Lowest set bit wins.

Test Plan:
- Enable=8'h01, mode=0, irq_in[0] high at edge k -> irq_req=1, irq_vec=0 after k+1. Ack -> INSERVICE reads 8'h01. EOI -> reads 0, irq_req remains 0 until next IDLE evaluation.
- Enable=8'hFF, irq_in=8'b0010_0100 simultaneously -> irq_vec=2. After ack+eoi, the next request gives irq_vec=5 if still pending.
- Edge channel 3, 1-cycle pulse, enable=0 -> PENDING reads 8'h08, no irq_req. Enable bit 3 -> irq_req after next cycle. W1C 8'h08 in the same cycle as a new edge on bit 3 -> pending stays set.
- In REQ with irq_vec=4, assert irq_in[1] -> irq_vec stays 4 until ack. After eoi, vector 1 is served.
- Reset asserted in SERVICE -> next cycle irq_req=0, irq_vec=0, all registers 0. A stray irq_eoi is ignored.
- With IRQ_SYNC_EN: irq_in[0] high at edge k -> irq_req=1 after k+3.
